// File: rtl/writeback_pkg.sv
// Shared types and helpers for the register-file writeback queue.
//   WB_ADR_W / WB_DATA_W : default register address / data widths
//   wb_entry_t           : one queued write request {adr, data}
//   ptr_inc()            : circular-pointer increment modulo a queue depth
package writeback_pkg;

    localparam int unsigned WB_ADR_W  = 6;
    localparam int unsigned WB_DATA_W = 64;
    // Widest pointer needed for the largest supported depth (16).
    localparam int unsigned PTR_MAX_W = 4;

    typedef struct packed {
        logic [WB_ADR_W-1:0]  adr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [PTR_MAX_W-1:0] ptr_inc(input logic [PTR_MAX_W-1:0] ptr,
                                                     input int unsigned depth);
        logic [PTR_MAX_W-1:0] last;
        last = PTR_MAX_W'(depth - 1);
        return (ptr == last) ? '0 : ptr + PTR_MAX_W'(1);
    endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// Bus bundle between the execute stage, the writeback queue and the register file.
//   request channel : reqValid/reqReady/reqAdr/reqData, stall
//   write port      : writeAdr/writeData/writeEnable
//   snoop/forward   : readAdr1/2 in, fwdHit1/2 and fwdData1/2 out
//   status          : count, empty, full
// master = producer / surrounding pipeline, slave = the queue.
interface writeback_queue_if
    import writeback_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADR_W  = WB_ADR_W,
    parameter int unsigned DATA_W = WB_DATA_W
);
    logic                     reqValid;
    logic                     reqReady;
    logic [ADR_W-1:0]         reqAdr;
    logic [DATA_W-1:0]        reqData;
    logic                     stall;
    logic [ADR_W-1:0]         writeAdr;
    logic [DATA_W-1:0]        writeData;
    logic                     writeEnable;
    logic [ADR_W-1:0]         readAdr1;
    logic [ADR_W-1:0]         readAdr2;
    logic                     fwdHit1;
    logic                     fwdHit2;
    logic [DATA_W-1:0]        fwdData1;
    logic [DATA_W-1:0]        fwdData2;
    logic [$clog2(DEPTH):0]   count;
    logic                     empty;
    logic                     full;

    modport master (
        output reqValid, reqAdr, reqData, stall, readAdr1, readAdr2,
        input  reqReady, writeAdr, writeData, writeEnable,
               fwdHit1, fwdHit2, fwdData1, fwdData2, count, empty, full
    );

    modport slave (
        input  reqValid, reqAdr, reqData, stall, readAdr1, readAdr2,
        output reqReady, writeAdr, writeData, writeEnable,
               fwdHit1, fwdHit2, fwdData1, fwdData2, count, empty, full
    );
endinterface

// File: rtl/wbq_fwd_select.sv
// Forwarding selector for one register-file read port.
//   entries   : queue storage
//   validMask : which slots currently hold queued writes
//   tail      : next free slot (the youngest entry sits just below it)
//   readAdr   : snooped read address
//   hit/data  : any valid slot matches / data of the youngest match (0 on miss)
module wbq_fwd_select
    import writeback_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADR_W  = WB_ADR_W,
    parameter int unsigned DATA_W = WB_DATA_W
) (
    input  wb_entry_t                  entries [DEPTH],
    input  logic [DEPTH-1:0]           validMask,
    input  logic [$clog2(DEPTH)-1:0]   tail,
    input  logic [ADR_W-1:0]           readAdr,
    output logic                       hit,
    output logic [DATA_W-1:0]          data
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        // Walk from tail-DEPTH (oldest) up to tail-1 (youngest); the last match wins.
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail - PTR_W'(k);
            if (validMask[idx] && entries[idx].adr == readAdr) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: buffers register-file write requests and drains one per cycle into
// the single register-file write port, forwarding queued data to two read ports.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of writeback_queue_if (request, write port, forward, status)
// ADR_W/DATA_W must match the package widths used by wb_entry_t.
module writeback_queue
    import writeback_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADR_W  = WB_ADR_W,
    parameter int unsigned DATA_W = WB_DATA_W
) (
    input logic              clk,
    input logic              rst_n,
    writeback_queue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] headQ, headD;
    logic [PTR_W-1:0] tailQ, tailD;
    logic [CNT_W-1:0] countQ, countD;
    wb_entry_t        entriesQ [DEPTH];
    logic [DEPTH-1:0] validMask;
    logic             push, pop, isEmpty, isFull;

    assign isEmpty = (countQ == '0);
    assign isFull  = (countQ == CNT_W'(DEPTH));
    // Full blocks a push even when a pop frees a slot on the same edge.
    assign push    = bus.reqValid && !isFull;
    assign pop     = !isEmpty && !bus.stall;

    always_comb begin
        headD  = headQ;
        tailD  = tailQ;
        countD = countQ;
        if (pop) begin
            headD = PTR_W'(ptr_inc(PTR_MAX_W'(headQ), DEPTH));
        end
        if (push) begin
            tailD = PTR_W'(ptr_inc(PTR_MAX_W'(tailQ), DEPTH));
        end
        if (push && !pop) begin
            countD = countQ + CNT_W'(1);
        end else if (pop && !push) begin
            countD = countQ - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headQ  <= '0;
            tailQ  <= '0;
            countQ <= '0;
        end else begin
            headQ  <= headD;
            tailQ  <= tailD;
            countQ <= countD;
        end
    end

    // Storage needs no reset: slots outside the valid window are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            entriesQ[tailQ] <= '{adr: bus.reqAdr, data: bus.reqData};
        end
    end

    // A slot is valid when its distance from head is below the occupancy.
    always_comb begin
        logic [PTR_W-1:0] offs;
        offs      = '0;
        validMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs         = PTR_W'(i) - headQ;
            validMask[i] = (CNT_W'(offs) < countQ);
        end
    end

    assign bus.reqReady    = !isFull;
    assign bus.writeEnable = pop;
    assign bus.writeAdr    = isEmpty ? '0 : entriesQ[headQ].adr;
    assign bus.writeData   = isEmpty ? '0 : entriesQ[headQ].data;
    assign bus.count       = countQ;
    assign bus.empty       = isEmpty;
    assign bus.full        = isFull;

    wbq_fwd_select #(
        .DEPTH  (DEPTH),
        .ADR_W  (ADR_W),
        .DATA_W (DATA_W)
    ) u_fwd1 (
        .entries   (entriesQ),
        .validMask (validMask),
        .tail      (tailQ),
        .readAdr   (bus.readAdr1),
        .hit       (bus.fwdHit1),
        .data      (bus.fwdData1)
    );

    wbq_fwd_select #(
        .DEPTH  (DEPTH),
        .ADR_W  (ADR_W),
        .DATA_W (DATA_W)
    ) u_fwd2 (
        .entries   (entriesQ),
        .validMask (validMask),
        .tail      (tailQ),
        .readAdr   (bus.readAdr2),
        .hit       (bus.fwdHit2),
        .data      (bus.fwdData2)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// Testbench for writeback_queue: directed scenarios with literal expectations plus a
// queue-based reference model compared against the DUT on every falling clock edge.
module tb_writeback_queue;

    localparam int DEPTH  = 4;
    localparam int ADR_W  = 6;
    localparam int DATA_W = 64;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    writeback_queue_if #(.DEPTH(DEPTH), .ADR_W(ADR_W), .DATA_W(DATA_W)) bus ();

    writeback_queue #(
        .DEPTH  (DEPTH),
        .ADR_W  (ADR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nChecks = 0;
    int nPass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [5:0]  adr;
        logic [63:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] regsModel [64];   // register file as the model says it should be
    logic [63:0] rfDut     [64];   // register file fed by the DUT write port

    function automatic void youngest(input logic [5:0] a, output logic hit,
                                     output logic [63:0] d);
        hit = 1'b0;
        d   = '0;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].adr == a) begin
                hit = 1'b1;
                d   = mq[i].data;
            end
        end
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) begin
            regsModel[i] = '0;
            rfDut[i]     = '0;
        end
    end

    // Model state update: pop head if non-empty and not stalled, push if not full.
    initial forever begin
        bit doPop;
        bit doPush;
        ent_t e;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
        end else begin
            doPop  = (mq.size() > 0) && !bus.stall;
            doPush = bus.reqValid && (mq.size() < DEPTH);
            if (doPop) begin
                regsModel[mq[0].adr] = mq[0].data;
                void'(mq.pop_front());
            end
            if (doPush) begin
                e.adr  = bus.reqAdr;
                e.data = bus.reqData;
                mq.push_back(e);
            end
        end
    end

    // Register file driven by the DUT's write port.
    initial forever begin
        @(posedge clk);
        if (bus.writeEnable) rfDut[bus.writeAdr] = bus.writeData;
    end

    // Per-cycle comparison against the model.
    initial forever begin
        logic        h1, h2;
        logic [63:0] d1, d2, v1, v2;
        int          n;
        @(negedge clk);
        n = mq.size();
        youngest(bus.readAdr1, h1, d1);
        youngest(bus.readAdr2, h2, d2);
        v1 = h1 ? d1 : regsModel[bus.readAdr1];
        v2 = h2 ? d2 : regsModel[bus.readAdr2];
        chk("count", 64'(bus.count), 64'(n));
        chk("empty", 64'(bus.empty), 64'(n == 0));
        chk("full", 64'(bus.full), 64'(n == DEPTH));
        chk("reqReady", 64'(bus.reqReady), 64'(n != DEPTH));
        chk("writeEnable", 64'(bus.writeEnable), 64'((n > 0) && !bus.stall && rst_n));
        chk("writeAdr", 64'(bus.writeAdr), (n > 0) ? 64'(mq[0].adr) : 64'(0));
        chk("writeData", bus.writeData, (n > 0) ? mq[0].data : 64'(0));
        chk("fwdHit1", 64'(bus.fwdHit1), 64'(h1));
        chk("fwdData1", bus.fwdData1, d1);
        chk("fwdHit2", 64'(bus.fwdHit2), 64'(h2));
        chk("fwdData2", bus.fwdData2, d2);
        chk("readVal1", bus.fwdHit1 ? bus.fwdData1 : rfDut[bus.readAdr1], v1);
        chk("readVal2", bus.fwdHit2 ? bus.fwdData2 : rfDut[bus.readAdr2], v2);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] a, input logic [63:0] d);
        bus.reqValid = v;
        bus.reqAdr   = a;
        bus.reqData  = d;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.stall    = 1'b0;
        bus.readAdr1 = '0;
        bus.readAdr2 = '0;
        drive(1'b0, '0, '0);
        #2;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_reqReady", 64'(bus.reqReady), 64'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Single write latency
        tick();
        drive(1'b1, 6'd5, 64'hDEAD);
        bus.readAdr1 = 6'd5;
        tick();
        drive(1'b0, '0, '0);
        chk("lat_we", 64'(bus.writeEnable), 64'd1);
        chk("lat_adr", 64'(bus.writeAdr), 64'd5);
        chk("lat_data", bus.writeData, 64'hDEAD);
        chk("lat_hit", 64'(bus.fwdHit1), 64'd1);
        chk("lat_fwd", bus.fwdData1, 64'hDEAD);
        tick();
        chk("lat_hit_after", 64'(bus.fwdHit1), 64'd0);
        chk("lat_rf", rfDut[5], 64'hDEAD);
        chk("lat_empty", 64'(bus.empty), 64'd1);

        // Fill while stalled, then drain in order
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 6'(10 + i), 64'(100 + i));
            tick();
        end
        drive(1'b1, 6'd20, 64'd999);
        chk("fill_full", 64'(bus.full), 64'd1);
        chk("fill_ready", 64'(bus.reqReady), 64'd0);
        tick();
        chk("fill_reject", 64'(bus.count), 64'd4);
        drive(1'b0, '0, '0);
        bus.stall = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_adr", 64'(bus.writeAdr), 64'(10 + i));
            chk("drain_data", bus.writeData, 64'(100 + i));
            tick();
        end
        chk("drain_empty", 64'(bus.empty), 64'd1);
        chk("drain_no20", rfDut[20], 64'd0);

        // Duplicate addresses: youngest forwards, oldest written first
        bus.stall = 1'b1;
        drive(1'b1, 6'd7, 64'd1);
        tick();
        drive(1'b1, 6'd7, 64'd2);
        tick();
        drive(1'b0, '0, '0);
        bus.readAdr2 = 6'd7;
        #1;
        chk("dup_hit", 64'(bus.fwdHit2), 64'd1);
        chk("dup_fwd", bus.fwdData2, 64'd2);
        bus.stall = 1'b0;
        #1;
        chk("dup_w1", bus.writeData, 64'd1);
        chk("dup_fwd1", bus.fwdData2, 64'd2);
        tick();
        chk("dup_w2", bus.writeData, 64'd2);
        chk("dup_fwd2", bus.fwdData2, 64'd2);
        tick();
        chk("dup_hit_end", 64'(bus.fwdHit2), 64'd0);
        chk("dup_rf", rfDut[7], 64'd2);

        // Simultaneous push/pop at count=2 across pointer wrap
        bus.stall = 1'b1;
        drive(1'b1, 6'd30, 64'd300);
        tick();
        drive(1'b1, 6'd31, 64'd301);
        tick();
        bus.stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 6'(32 + i), 64'(302 + i));
            tick();
            chk("pp_count", 64'(bus.count), 64'd2);
        end
        drive(1'b0, '0, '0);
        tick();
        tick();
        chk("pp_empty", 64'(bus.empty), 64'd1);
        chk("pp_rf39", rfDut[39], 64'd309);

        // Reset mid-drain
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'(50 + i), 64'(64'h500 + i));
            tick();
        end
        drive(1'b0, '0, '0);
        bus.readAdr1 = 6'd50;
        #1;
        chk("mid_count", 64'(bus.count), 64'd3);
        chk("mid_hit", 64'(bus.fwdHit1), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_count", 64'(bus.count), 64'd0);
        chk("ar_empty", 64'(bus.empty), 64'd1);
        chk("ar_we", 64'(bus.writeEnable), 64'd0);
        chk("ar_ready", 64'(bus.reqReady), 64'd1);
        chk("ar_hit", 64'(bus.fwdHit1), 64'd0);
        chk("ar_wadr", 64'(bus.writeAdr), 64'd0);
        tick();
        rst_n     = 1'b1;
        bus.stall = 1'b0;
        repeat (3) tick();
        chk("ar_nowrite_we", 64'(bus.writeEnable), 64'd0);
        chk("ar_nowrite_rf", rfDut[50], 64'd0);

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            drive(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                  {32'($urandom), 32'($urandom)});
            bus.stall    = ($urandom_range(0, 3) == 0);
            bus.readAdr1 = 6'($urandom_range(0, 7));
            bus.readAdr2 = 6'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 63)
                                                          : $urandom_range(0, 7));
            tick();
        end
        drive(1'b0, '0, '0);
        bus.stall = 1'b0;
        repeat (DEPTH + 2) tick();
        chk("final_empty", 64'(bus.empty), 64'd1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
